// File: rtl/cnn_mul_share_arb_pkg.sv
// cnn_mul_share_arb_pkg: shared widths, operand and pipeline-stage types for the multiplier arbiter
// No ports; NUM_REQ/A_W/B_W/P_W/TAG_W are fixed here so the interface, arbiter and top agree.
package cnn_mul_share_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int A_W = 14;
  localparam int B_W = 8;
  localparam int P_W = A_W + B_W;
  localparam int TAG_W = $clog2(NUM_REQ);
  typedef struct packed {
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
  } operand_t;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic signed [P_W-1:0] p;
  } stage_t;
endpackage

// File: rtl/cnn_mul_share_arb_if.sv
// cnn_mul_share_arb_if: requester operand handshake and tagged product return bus
// master (requesters): drives req_valid/req_a/req_b, sees req_ready/rsp_valid/rsp_p.
// slave (arbiter): the mirror image.
interface cnn_mul_share_arb_if import cnn_mul_share_arb_pkg::*; ();
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0] rsp_valid;
  logic signed [P_W-1:0] rsp_p;
  modport master(output req_valid, req_a, req_b, input req_ready, rsp_valid, rsp_p);
  modport slave(input req_valid, req_a, req_b, output req_ready, rsp_valid, rsp_p);
endinterface

// File: rtl/cnn_mul_share_rr.sv
// cnn_mul_share_rr: combinational round-robin pick of the first request at or after ptr
// Ports: req (requests), ptr (search start) -> gnt (one-hot), idx (winner), any (some request).
module cnn_mul_share_rr import cnn_mul_share_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [TAG_W-1:0]   idx,
  output logic               any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[TAG_W'(j)]) begin
        idx = TAG_W'(j);
        any = 1'b1;
      end
    end
    gnt = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/cnn_mul_share_arb.sv
// cnn_mul_share_arb: round-robin sharing of one pipelined signed 14x8 multiplier among NUM_REQ requesters
// Ports: ap_clk, ap_rst_n (async, active low), flush (sync pipeline clear), bus (slave side of
// cnn_mul_share_arb_if), busy (any stage valid), perf_grant_cnt / perf_stall_cnt (counters).
// Define CNN_MUL_SHARE_ARB_PERF_EN to build the counters; otherwise they read as 0.
module cnn_mul_share_arb import cnn_mul_share_arb_pkg::*; #(
  parameter int MUL_LAT = 2
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      flush,
  cnn_mul_share_arb_if.slave        bus,
  output logic                      busy,
  output logic [NUM_REQ*32-1:0]     perf_grant_cnt,
  output logic [31:0]               perf_stall_cnt
);
  logic [TAG_W-1:0] ptr, idx;
  logic [NUM_REQ-1:0] gnt;
  logic any, acc;
  operand_t op;
  stage_t [MUL_LAT-1:0] st, prv;
  cnn_mul_share_rr u_rr (.req(bus.req_valid), .ptr(ptr), .gnt(gnt), .idx(idx), .any(any));
  assign bus.req_ready = (ap_rst_n && !flush && any) ? gnt : '0;
  assign acc = |bus.req_ready;
  assign op = {bus.req_a[idx*A_W +: A_W], bus.req_b[idx*B_W +: B_W]};
  // Stage 1 takes the full product; later stages only retime it.
  always_comb begin
    prv[0] = '{valid: acc, tag: idx, p: P_W'(op.a) * P_W'(op.b)};
    for (int k = 1; k < MUL_LAT; k++) prv[k] = st[k-1];
    busy = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) busy = busy | st[k].valid;
  end
  // Product fields load only with a live op so rsp_p holds between results.
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      ptr <= '0;
      st <= '0;
    end else begin
      if (acc) ptr <= (idx == TAG_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      for (int k = 0; k < MUL_LAT; k++) begin
        st[k].valid <= prv[k].valid && !flush;
        st[k].tag <= prv[k].tag;
        if (prv[k].valid && !flush) st[k].p <= prv[k].p;
      end
    end
  // A result leaving the pipe in a flush cycle is dropped.
  assign bus.rsp_valid = (st[MUL_LAT-1].valid && !flush) ? NUM_REQ'(1) << st[MUL_LAT-1].tag : '0;
  assign bus.rsp_p = st[MUL_LAT-1].p;
`ifdef CNN_MUL_SHARE_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] gcnt;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      gcnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k]) gcnt[k] <= gcnt[k] + 32'd1;
      if (|(bus.req_valid & ~bus.req_ready)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  assign perf_grant_cnt = gcnt;
`else
  assign perf_grant_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule
